// File: rtl/inst_queue_param_pkg.sv
// Shared decoded-packet layout and helpers used by decode, the instruction queue and dispatch.
package inst_queue_param_pkg;

   localparam int DEC_PKT_W  = 32;
   localparam int DEC_BR_BIT = 31;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Instruction queue storage: multi-port synchronous write, asynchronous read.
module inst_queue_ram import inst_queue_param_pkg::*; #(
   parameter int DEPTH = 32,
   parameter int PKT_W = DEC_PKT_W,
   parameter int WR_N  = 8,
   parameter int RD_N  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WR_N-1:0]              we,
   input  logic [WR_N*clog2(DEPTH)-1:0] waddr,
   input  logic [WR_N*PKT_W-1:0]        wdata,
   input  logic [RD_N*clog2(DEPTH)-1:0] raddr,
   output logic [RD_N*PKT_W-1:0]        rdata
);

   localparam int AW = clog2(DEPTH);

   logic [PKT_W-1:0] mem [DEPTH];

   // Cleared on reset so unused dispatch lanes never read X.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int w = 0; w < WR_N; w++) begin
            if (we[w]) mem[waddr[w*AW +: AW]] <= wdata[w*PKT_W +: PKT_W];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int r = 0; r < RD_N; r++) begin
         rdata[r*PKT_W +: PKT_W] = mem[raddr[r*AW +: AW]];
      end
   end

endmodule

// File: rtl/inst_queue_param.sv
// Decoupling instruction queue between decode and rename/dispatch with sparse-lane compaction.
module inst_queue_param import inst_queue_param_pkg::*; #(
   parameter int FETCH_W      = 8,
   parameter int DISPATCH_W   = 4,
   parameter int DEPTH        = 32,
   parameter int PKT_W        = DEC_PKT_W,
   parameter int BR_BIT       = DEC_BR_BIT,
   parameter int PARTIAL_DISP = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush_i,
   input  logic                          stall_i,
   input  logic                          decodeReady_i,
   input  logic [FETCH_W-1:0]            decodedVector_i,
   input  logic [FETCH_W*PKT_W-1:0]      decodedPkts_i,
   output logic                          stallFetch_o,
   output logic                          instBufferReady_o,
   output logic [DISPATCH_W-1:0]         dispatchValid_o,
   output logic [DISPATCH_W*PKT_W-1:0]   decodedPkts_o,
   output logic [clog2(DISPATCH_W):0]    branchCount_o,
   output logic [clog2(DEPTH):0]         instCount_o
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BC_W  = clog2(DISPATCH_W) + 1;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_W);
   localparam logic [CNT_W-1:0] DISP_C  = CNT_W'(DISPATCH_W);

   logic [PTR_W-1:0]            head_q;
   logic [PTR_W-1:0]            tail_q;
   logic [CNT_W-1:0]            count_q;
   logic                        push;
   logic [CNT_W-1:0]            n_push;
   logic [CNT_W-1:0]            n_avail;
   logic [CNT_W-1:0]            n_pop;
   logic [FETCH_W-1:0]          we;
   logic [FETCH_W*PTR_W-1:0]    waddr;
   logic [DISPATCH_W*PTR_W-1:0] raddr;

   // Registered count only: no combinational path from the decode inputs.
   assign stallFetch_o = (DEPTH_C - count_q) < FETCH_C;
   assign push         = decodeReady_i & ~stallFetch_o & ~flush_i;

   // Each valid lane lands at tail plus the number of valid lanes below it.
   always_comb begin
      n_push = '0;
      we     = '0;
      waddr  = '0;
      for (int k = 0; k < FETCH_W; k++) begin
         we[k] = push & decodedVector_i[k];
         waddr[k*PTR_W +: PTR_W] = tail_q + n_push[PTR_W-1:0];
         if (we[k]) n_push = n_push + CNT_W'(1);
      end
   end

   always_comb begin
      n_avail = '0;
      if (PARTIAL_DISP != 0) n_avail = (count_q < DISP_C) ? count_q : DISP_C;
      else                   n_avail = (count_q >= DISP_C) ? DISP_C : '0;
      n_pop = stall_i ? '0 : n_avail;
      dispatchValid_o = '0;
      raddr = '0;
      for (int j = 0; j < DISPATCH_W; j++) begin
         dispatchValid_o[j] = CNT_W'(j) < n_avail;
         raddr[j*PTR_W +: PTR_W] = head_q + PTR_W'(j);
      end
   end

   assign instBufferReady_o = |dispatchValid_o;
   assign instCount_o       = count_q;

   always_comb begin
      branchCount_o = '0;
      for (int j = 0; j < DISPATCH_W; j++) begin
         if (dispatchValid_o[j] && decodedPkts_o[j*PKT_W + BR_BIT])
            branchCount_o = branchCount_o + BC_W'(1);
      end
   end

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         tail_q  <= tail_q + n_push[PTR_W-1:0];
         head_q  <= head_q + n_pop[PTR_W-1:0];
         count_q <= count_q + n_push - n_pop;
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         assert (count_q <= DEPTH_C);
         assert (PTR_W'(tail_q - head_q) == count_q[PTR_W-1:0]);
      end
   end

   inst_queue_ram #(
      .DEPTH (DEPTH),
      .PKT_W (PKT_W),
      .WR_N  (FETCH_W),
      .RD_N  (DISPATCH_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (decodedPkts_i),
      .raddr (raddr),
      .rdata (decodedPkts_o)
   );

endmodule

// File: tb/tb_inst_queue_param.sv
// Directed bench for inst_queue_param: full-dispatch instance first, then a partial-dispatch instance.
module tb_inst_queue_param;
   import inst_queue_param_pkg::*;

   localparam int FW  = 8;
   localparam int DW  = 4;
   localparam int DEP = 32;
   localparam int PW  = DEC_PKT_W;
   localparam int BB  = DEC_BR_BIT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset0, reset_p, flush, stall, dready;
   logic [FW-1:0] vec;
   logic [FW*PW-1:0] pkts;

   logic          sf, ibr, sf_p, ibr_p;
   logic [DW-1:0] dv, dv_p;
   logic [DW*PW-1:0] dpk, dpk_p;
   logic [2:0]    bc, bc_p;
   logic [5:0]    cnt, cnt_p;

   int n_checks = 0;
   int n_err    = 0;

   inst_queue_param #(.FETCH_W(FW), .DISPATCH_W(DW), .DEPTH(DEP), .PKT_W(PW),
                      .BR_BIT(BB), .PARTIAL_DISP(0)) dut (
      .clk(clk), .reset(reset0), .flush_i(flush), .stall_i(stall),
      .decodeReady_i(dready), .decodedVector_i(vec), .decodedPkts_i(pkts),
      .stallFetch_o(sf), .instBufferReady_o(ibr), .dispatchValid_o(dv),
      .decodedPkts_o(dpk), .branchCount_o(bc), .instCount_o(cnt));

   inst_queue_param #(.FETCH_W(FW), .DISPATCH_W(DW), .DEPTH(DEP), .PKT_W(PW),
                      .BR_BIT(BB), .PARTIAL_DISP(1)) dut_p (
      .clk(clk), .reset(reset_p), .flush_i(flush), .stall_i(stall),
      .decodeReady_i(dready), .decodedVector_i(vec), .decodedPkts_i(pkts),
      .stallFetch_o(sf_p), .instBufferReady_o(ibr_p), .dispatchValid_o(dv_p),
      .decodedPkts_o(dpk_p), .branchCount_o(bc_p), .instCount_o(cnt_p));

   function automatic logic [PW-1:0] mk(input logic br, input int tag);
      logic [PW-1:0] p;
      p = PW'(tag);
      p[BB] = br;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_lane(input string tag, input logic [DW*PW-1:0] win, input int j,
                           input logic br, input int t);
      chk(tag, 64'(win[j*PW +: PW]), 64'(mk(br, t)));
   endtask

   task automatic load_tags(input int base, input logic [FW-1:0] brmask);
      for (int k = 0; k < FW; k++) pkts[k*PW +: PW] = mk(brmask[k], base + k);
   endtask

   initial begin
      reset0 = 1'b1; reset_p = 1'b1; flush = 1'b0; stall = 1'b1;
      dready = 1'b0; vec = '0; pkts = '0;
      tick(); tick();
      chk("rst_cnt",  64'(cnt), 64'd0);
      chk("rst_sf",   64'(sf),  64'd0);
      chk("rst_dv",   64'(dv),  64'd0);
      chk("rst_ibr",  64'(ibr), 64'd0);
      chk("rst_bc",   64'(bc),  64'd0);
      chk("rst_cnt_p", 64'(cnt_p), 64'd0);

      // Fill to full with back-end stalled
      reset0 = 1'b0; dready = 1'b1; vec = 8'hFF;
      load_tags(0, 8'h00);  tick();
      chk("fill8", 64'(cnt), 64'd8);
      load_tags(8, 8'h00);  tick();
      chk("fill16", 64'(cnt), 64'd16);
      chk("fill16_sf", 64'(sf), 64'd0);
      load_tags(16, 8'h00); tick();
      chk("fill24", 64'(cnt), 64'd24);
      chk("fill24_sf", 64'(sf), 64'd0);
      load_tags(24, 8'h00); tick();
      chk("fill32", 64'(cnt), 64'd32);
      chk("fill32_sf", 64'(sf), 64'd1);
      load_tags(200, 8'h00); tick();
      chk("full_ignored", 64'(cnt), 64'd32);
      chk("full_dv", 64'(dv), 64'hF);
      for (int j = 0; j < DW; j++) chk_lane("full_lane", dpk, j, 1'b0, j);

      // Drain in groups of four
      dready = 1'b0; stall = 1'b0;
      tick();
      chk("drain_cnt28", 64'(cnt), 64'd28);
      chk_lane("drain_lane0", dpk, 0, 1'b0, 4);
      repeat (7) tick();
      chk("drain_cnt0", 64'(cnt), 64'd0);
      chk("drain_dv0", 64'(dv), 64'd0);

      // Sparse push: lanes 0,2,5,7; branch flags on lanes 2 and 7
      stall = 1'b1; dready = 1'b1; vec = 8'b1010_0101;
      load_tags(0, 8'b1000_0100); tick();
      chk("sparse_cnt", 64'(cnt), 64'd4);
      chk("sparse_dv", 64'(dv), 64'hF);
      chk_lane("sparse_l0", dpk, 0, 1'b0, 0);
      chk_lane("sparse_l1", dpk, 1, 1'b1, 2);
      chk_lane("sparse_l2", dpk, 2, 1'b0, 5);
      chk_lane("sparse_l3", dpk, 3, 1'b1, 7);
      chk("sparse_bc", 64'(bc), 64'd2);

      vec = 8'h3F; load_tags(32, 8'h00); tick();
      chk("cnt10", 64'(cnt), 64'd10);
      chk("cnt10_bc", 64'(bc), 64'd2);

      // Simultaneous push 6 / pop 4
      stall = 1'b0; vec = 8'h3F; load_tags(48, 8'h00);
      chk("pp_sf", 64'(sf), 64'd0);
      tick();
      chk("pp_cnt", 64'(cnt), 64'd12);
      chk_lane("pp_l0", dpk, 0, 1'b0, 32);
      chk_lane("pp_l3", dpk, 3, 1'b0, 35);
      chk("pp_bc", 64'(bc), 64'd0);

      // Flush with concurrent push and pop at count 20
      stall = 1'b1; vec = 8'hFF; load_tags(64, 8'h00); tick();
      chk("pre_flush_cnt", 64'(cnt), 64'd20);
      flush = 1'b1; stall = 1'b0; tick();
      chk("flush_cnt", 64'(cnt), 64'd0);
      chk("flush_dv", 64'(dv), 64'd0);
      chk("flush_sf", 64'(sf), 64'd0);
      chk("flush_ibr", 64'(ibr), 64'd0);
      flush = 1'b0;

      // Full-dispatch mode holds back a partial window
      vec = 8'h07; load_tags(80, 8'h00); tick();
      dready = 1'b0;
      chk("nopart_cnt3", 64'(cnt), 64'd3);
      chk("nopart_dv", 64'(dv), 64'd0);
      chk("nopart_ibr", 64'(ibr), 64'd0);
      tick();
      chk("nopart_hold", 64'(cnt), 64'd3);

      // Partial-dispatch instance
      reset0 = 1'b1; reset_p = 1'b0;
      stall = 1'b1; dready = 1'b1; vec = 8'h07; load_tags(96, 8'h00); tick();
      chk("part_cnt3", 64'(cnt_p), 64'd3);
      chk("part_dv", 64'(dv_p), 64'h7);
      chk("part_ibr", 64'(ibr_p), 64'd1);
      chk_lane("part_l2", dpk_p, 2, 1'b0, 98);
      dready = 1'b0; stall = 1'b0; tick();
      chk("part_pop", 64'(cnt_p), 64'd0);
      chk("part_dv0", 64'(dv_p), 64'd0);

      // Move head/tail to 30
      stall = 1'b1; dready = 1'b1; vec = 8'hFF; load_tags(112, 8'h00);
      repeat (3) tick();
      vec = 8'h07; tick();
      chk("adv_cnt27", 64'(cnt_p), 64'd27);
      dready = 1'b0; stall = 1'b0;
      repeat (7) tick();
      chk("adv_cnt0", 64'(cnt_p), 64'd0);

      // Wrap-around: slots 30,31,0..5
      stall = 1'b1; dready = 1'b1; vec = 8'hFF; load_tags(144, 8'h00); tick();
      chk("wrap_cnt8", 64'(cnt_p), 64'd8);
      for (int j = 0; j < DW; j++) chk_lane("wrap_pop0", dpk_p, j, 1'b0, 144 + j);
      dready = 1'b0; stall = 1'b0; tick();
      chk("wrap_cnt4", 64'(cnt_p), 64'd4);
      for (int j = 0; j < DW; j++) chk_lane("wrap_pop1", dpk_p, j, 1'b0, 148 + j);
      tick();
      chk("wrap_cnt0", 64'(cnt_p), 64'd0);
      chk("wrap_dv0", 64'(dv_p), 64'd0);
      chk("wrap_sf", 64'(sf_p), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
